// File: rtl/irq_ctrl_pkg.sv
// Shared definitions for the CP0 interrupt source: FSM encoding, ERET opcode and level constants.
package irq_ctrl_pkg;
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } state_t;

    localparam int         LVL_W       = 3;
    localparam logic [2:0] OP_ERET     = 3'd3;
    localparam logic [2:0] LVL_NONE    = 3'd0;
    localparam int         STACK_DEPTH = 3;
endpackage

// File: rtl/irq_ctrl_sync_edge.sv
// One external IRQ line: 2-FF synchroniser followed by a rising-edge detector (1-cycle pulse).
module irq_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_rise
);
    logic r_meta;
    logic r_sync;
    logic r_prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_rise = r_sync & ~r_prev;
endmodule

// File: rtl/irq_ctrl.sv
// Interrupt source beside cp0: latches masked IRQ edges, arbitrates by level, holds the request
// until exceptClear, and tracks nested in-service levels that ERET unwinds.
module irq_ctrl
    import irq_ctrl_pkg::*;
#(
    parameter int                   N_IRQ       = 6,
    parameter logic [2*N_IRQ-1:0]   LEVEL_MAP   = 12'b11_11_10_10_01_01,
    parameter int                   ACK_TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_IRQ-1:0] irq_in,
    input  logic             mask_we,
    input  logic [N_IRQ-1:0] mask_wdata,
    input  logic [2:0]       cp_oper,
    input  logic [2:0]       cause,
    input  logic             exceptClear,
    output logic [2:0]       interruptSignal,
    output logic [N_IRQ-1:0] pending,
    output logic [N_IRQ-1:0] mask,
    output logic [2:0]       in_service_lvl,
    output logic             irq_busy
);
    localparam int IDX_W  = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;
    localparam int TCNT_W = $clog2(ACK_TIMEOUT + 1);

    logic [N_IRQ-1:0] w_rise;
    logic [N_IRQ-1:0] w_active;
    logic [N_IRQ-1:0] w_clr;
    logic [LVL_W-1:0] w_req_lvl;
    logic [IDX_W-1:0] w_req_idx;
    logic             w_eret;

    state_t           r_state;
    logic [N_IRQ-1:0] r_pending;
    logic [N_IRQ-1:0] r_mask;
    logic [LVL_W-1:0] r_int_sig;
    logic [LVL_W-1:0] r_isl;
    logic [LVL_W-1:0] r_stack [0:STACK_DEPTH-1];
    logic [1:0]       r_depth;
    logic [TCNT_W-1:0] r_tcnt;
    logic [IDX_W-1:0] r_req_idx;
    logic [LVL_W-1:0] r_req_lvl;
    logic             r_exc_flag;

    for (genvar g = 0; g < N_IRQ; g++) begin : g_line
        irq_sync_edge u_sync (
            .clk     (clk),
            .rst     (rst),
            .i_async (irq_in[g]),
            .o_rise  (w_rise[g])
        );
    end

    assign w_active = r_pending & r_mask;
    assign w_eret   = (cp_oper == OP_ERET);

    // Strict '>' keeps the lowest index among lines sharing the top level.
    always_comb begin
        w_req_lvl = LVL_NONE;
        w_req_idx = '0;
        for (int i = 0; i < N_IRQ; i++) begin
            if (w_active[i] && ({1'b0, LEVEL_MAP[2*i +: 2]} > w_req_lvl)) begin
                w_req_lvl = {1'b0, LEVEL_MAP[2*i +: 2]};
                w_req_idx = IDX_W'(i);
            end
        end
    end

    assign w_clr = (r_state == ST_REQ && exceptClear) ? (N_IRQ'(1) << r_req_idx) : '0;

    // A new edge in the ack cycle re-arms the line: set is applied after clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pending <= '0;
            r_mask    <= '1;
        end else begin
            r_pending <= (r_pending & ~w_clr) | (w_rise & r_mask);
            if (mask_we)
                r_mask <= mask_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_exc_flag <= 1'b0;
        else if (cause != 3'd0)
            r_exc_flag <= 1'b1;
        else if (w_eret && r_exc_flag)
            r_exc_flag <= 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_int_sig <= LVL_NONE;
            r_isl     <= LVL_NONE;
            r_depth   <= 2'd0;
            r_tcnt    <= '0;
            r_req_idx <= '0;
            r_req_lvl <= LVL_NONE;
            for (int i = 0; i < STACK_DEPTH; i++)
                r_stack[i] <= LVL_NONE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_req_lvl != LVL_NONE && !r_exc_flag) begin
                        r_req_idx <= w_req_idx;
                        r_req_lvl <= w_req_lvl;
                        r_int_sig <= w_req_lvl;
                        r_tcnt    <= '0;
                        r_state   <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (exceptClear) begin
                        if (r_depth != 2'(STACK_DEPTH)) begin
                            r_stack[r_depth] <= r_isl;
                            r_depth          <= r_depth + 2'd1;
                        end
                        r_isl     <= r_req_lvl;
                        r_int_sig <= LVL_NONE;
                        r_state   <= ST_SERVICE;
                    end else if (r_tcnt == TCNT_W'(ACK_TIMEOUT - 1)) begin
                        // Withdraw; the still-pending line is re-arbitrated next cycle.
                        r_int_sig <= LVL_NONE;
                        r_state   <= (r_depth == 2'd0) ? ST_IDLE : ST_SERVICE;
                    end else begin
                        r_tcnt <= r_tcnt + TCNT_W'(1);
                    end
                end
                ST_SERVICE: begin
                    if (w_req_lvl > r_isl && !r_exc_flag) begin
                        r_req_idx <= w_req_idx;
                        r_req_lvl <= w_req_lvl;
                        r_int_sig <= w_req_lvl;
                        r_tcnt    <= '0;
                        r_state   <= ST_REQ;
                    end else if (w_eret && !r_exc_flag && r_depth != 2'd0) begin
                        r_isl   <= r_stack[r_depth - 2'd1];
                        r_depth <= r_depth - 2'd1;
                        if (r_depth == 2'd1)
                            r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign interruptSignal = r_exc_flag ? LVL_NONE : r_int_sig;
    assign pending         = r_pending;
    assign mask            = r_mask;
    assign in_service_lvl  = r_isl;
    assign irq_busy        = (r_state != ST_IDLE);
endmodule
